mips_dmem_responder: RTL and testbench
======================================

# mips_dmem_responder

Data-side memory responder for the single-cycle MIPS core: it answers the core's data accesses (address, write strobe, write data) with same-cycle read data. It holds a word-addressed data RAM and a small memory-mapped I/O page with a cycle counter, a countdown timer, and a console byte FIFO drained over a valid/ready handshake. It sits beside the core at the top level, wired to the core's `memwrite`, ALU-result address, `writedata` and `readdata`.

## Interface
- `DEPTH`, 64: RAM size in 32-bit words, power of two, at least 2.
- `FIFO_DEPTH`, 8: console FIFO entries, power of two, from 2 to 15.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `memwrite`  in  1  write strobe from core.
- `dataadr`  in  32  byte address (core ALU result).
- `writedata`  in  32  store data.
- `readdata`  out  32  load data, combinational from `dataadr`.
- `cons_data`  out  8  FIFO head byte; 0 when FIFO is empty.
- `cons_valid`  out  1  FIFO non-empty.
- `cons_ready`  in  1  sink accepts the head byte.
- `timer_irq`  out  1  mirrors the STATUS.EXPIRED flag.

## Operation
- `dataadr[1:0]` is ignored everywhere. All accesses are whole words.
- **RAM region** (0x0000_0000 to 4*DEPTH-1):
  - Index is `dataadr[log2(DEPTH)+1:2]`.
  - A write stores `writedata`. A read returns the stored word.
- **MMIO page** (0xFFFF_FF00 to 0xFFFF_FF0F). Any other address is unmapped: reads return 0, writes are ignored.
- **0xFFFF_FF00 CYCLES** (read-only):
  - 32-bit counter, +1 every cycle, wraps 0xFFFF_FFFF to 0.
  - Writes are ignored.
- **0xFFFF_FF04 TIMER** (read/write):
  - A write loads `writedata`.
  - Otherwise, while nonzero, the counter decrements by 1 per cycle.
  - A decrement from 1 to 0 sets EXPIRED.
  - Loading 0 stops the timer without setting EXPIRED.
  - Load wins over a same-cycle decrement or expiry.
- **0xFFFF_FF08 STATUS**:
  - bit0 EXPIRED (sticky).
  - bit1 FULL.
  - bit2 EMPTY.
  - bit3 OVERFLOW (sticky).
  - bits[7:4] FIFO count.
  - Other bits read 0.
  - A write with bit0 or bit3 set clears that flag (write-1-to-clear).
  - A same-cycle set beats a clear.
- **0xFFFF_FF0C CONSOLE**:
  - A write pushes `writedata[7:0]`. Reads return 0.
  - The push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and OVERFLOW is set.
- **FIFO pop**: occurs when `cons_valid && cons_ready`.
  - Push and pop in the same cycle leave the count unchanged.
  - Head/tail pointers wrap modulo FIFO_DEPTH.
  - Ordering is strict FIFO.

## Timing
- `readdata` is combinational, valid in the same cycle as `dataadr`. There is zero-cycle read latency, as the single-cycle core requires.
- Writes commit at the rising edge. A read of the same address in the write cycle returns the old value.
- **STATUS read timing**: a STATUS read shows register values from before the current edge.
  - A CYCLES read at cycle N after reset release returns N-1, or the equivalent fixed offset. The bench checks the delta between reads.
- **Console output timing**:
  - A CONSOLE push at edge E raises `cons_valid` (if the FIFO was empty) in the cycle after E.
  - `cons_data` is stable while `cons_valid && !cons_ready`.
- **Reset values** (asserted asynchronously):
  - CYCLES=0, TIMER=0.
  - EXPIRED=0, OVERFLOW=0.
  - FIFO empty, so `cons_valid`=0, `cons_data`=0, `timer_irq`=0.
- RAM contents are not reset.
- Reset mid-transfer discards FIFO contents. No pop is reported.

## Structure
- Package `mips_mmio_pkg` holds:
  - Address constants: MMIO_BASE, CYCLES_ADR, TIMER_ADR, STATUS_ADR, CONSOLE_ADR.
  - STATUS bit indices: EXPIRED, FULL, EMPTY, OVERFLOW, COUNT_LSB.
- Sub-module `mips_console_fifo`:
  - Ports: push/data_in, pop handshake, count/full/empty.
  - Parameterized by FIFO_DEPTH, with the same clock and reset.
- Top holds the address decode, RAM array, CYCLES, TIMER and sticky flags.

## Test plan
- **RAM round trip**:
  - Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 → 0xDEADBEEF.
  - Read 0x0000_0013 → 0xDEADBEEF (low address bits ignored).
  - Read 0x0000_1000 with DEPTH=64 → 0.
- **Timer expiry**:
  - Write 3 to TIMER. Reads show 2, 1 on following cycles.
  - After 3 edges TIMER=0, `timer_irq`=1, STATUS bit0=1.
  - Write STATUS=0x1 → `timer_irq`=0.
  - Reload 5 in the cycle TIMER=1 → TIMER=5, no expiry.
- **Console ordering with backpressure**:
  - `cons_ready`=0. Push 0x41, 0x42, 0x43. STATUS count=3, EMPTY=0.
  - Raise `cons_ready` → sink sees 0x41, 0x42, 0x43 on consecutive cycles, then `cons_valid`=0.
- **Overflow**:
  - `cons_ready`=0. Push 9 bytes with FIFO_DEPTH=8. STATUS shows FULL=1, OVERFLOW=1, count=8.
  - The 9th byte is never emitted.
  - A push into a full FIFO with a simultaneous pop is accepted and does not set OVERFLOW.
- **Async reset mid-operation**:
  - With 4 bytes queued and TIMER=100, assert `reset`=0 between edges. Outputs go to reset values immediately.
  - After release, CYCLES restarts from 0 and `cons_valid`=0.
- **CYCLES wrap**:
  - Force the counter to 0xFFFF_FFFE via hierarchical deposit. Two edges later CYCLES reads 0x0000_0000.

Source files
------------

// File: rtl/mips_mmio_pkg.sv
// Address map and STATUS bit layout shared by the data-side memory responder
// and its console FIFO.
package mips_mmio_pkg;

    localparam logic [31:0] MMIO_BASE   = 32'hFFFF_FF00;
    localparam logic [31:0] CYCLES_ADR  = 32'hFFFF_FF00;
    localparam logic [31:0] TIMER_ADR   = 32'hFFFF_FF04;
    localparam logic [31:0] STATUS_ADR  = 32'hFFFF_FF08;
    localparam logic [31:0] CONSOLE_ADR = 32'hFFFF_FF0C;

    // STATUS bit positions
    localparam int EXPIRED   = 0;
    localparam int FULL      = 1;
    localparam int EMPTY     = 2;
    localparam int OVERFLOW  = 3;
    localparam int COUNT_LSB = 4;

    // Word slot within the 16-byte MMIO page, selected by address bits [3:2]
    typedef enum logic [1:0] {
        REG_CYCLES  = 2'd0,
        REG_TIMER   = 2'd1,
        REG_STATUS  = 2'd2,
        REG_CONSOLE = 2'd3
    } mmio_reg_e;

    // True when the byte address falls inside the 16-byte MMIO page
    function automatic logic is_mmio(input logic [31:0] adr);
        return adr[31:4] == MMIO_BASE[31:4];
    endfunction

endpackage

// File: rtl/mips_console_fifo.sv
// Console byte FIFO: core pushes bytes, an external sink drains them over a
// valid/ready handshake. A push into a full FIFO is still accepted when a pop
// happens in the same cycle; otherwise it is dropped and reported on 'drop'.
module mips_console_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] data_in,
    input  logic       ready,
    output logic [7:0] data_out,
    output logic       valid,
    output logic [3:0] count,
    output logic       full,
    output logic       empty,
    output logic       drop
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          pop;
    logic          push_ok;

    assign empty    = (count == 4'd0);
    assign full     = (count == 4'(FIFO_DEPTH));
    assign valid    = !empty;
    assign pop      = valid && ready;
    assign push_ok  = push && (!full || pop);
    assign drop     = push && full && !pop;
    assign data_out = empty ? 8'h00 : mem[head];

    // Storage array: written on accepted pushes only
    // NOTE: storage is deliberately left out of reset; the count/pointers
    // already mark every entry invalid, and a reset-free array maps to RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem[tail] <= data_in;
    end

    // Pointer and occupancy bookkeeping; power-of-two depth wraps naturally
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= 4'd0;
        end else begin
            if (push_ok) tail <= tail + 1'b1;
            if (pop)     head <= head + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-side memory responder for the single-cycle MIPS core: word RAM plus an
// MMIO page holding a cycle counter, a countdown timer, sticky status flags
// and a console FIFO. Reads are combinational; writes commit at the edge.
module mips_dmem_responder
    import mips_mmio_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  cons_data,
    output logic        cons_valid,
    input  logic        cons_ready,
    output logic        timer_irq
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   ram [DEPTH];
    logic [AW-1:0] ram_idx;
    logic          ram_hit;
    logic          mmio_hit;
    mmio_reg_e     mmio_sel;

    logic [31:0] cycles;
    logic [31:0] timer;
    logic        expired;
    logic        overflow;
    logic [31:0] status;

    logic        ram_we;
    logic        timer_we;
    logic        status_we;
    logic        console_we;
    logic        expire_set;

    logic [3:0]  fifo_count;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_drop;

    // Byte-offset bits never take part in decode; all accesses are words
    logic unused_adr_bits;
    assign unused_adr_bits = ^dataadr[1:0];

    assign ram_hit  = (dataadr[31:AW+2] == '0);
    assign ram_idx  = dataadr[AW+1:2];
    assign mmio_hit = is_mmio(dataadr);
    assign mmio_sel = mmio_reg_e'(dataadr[3:2]);

    assign ram_we     = memwrite && ram_hit;
    assign timer_we   = memwrite && mmio_hit && (mmio_sel == REG_TIMER);
    assign status_we  = memwrite && mmio_hit && (mmio_sel == REG_STATUS);
    assign console_we = memwrite && mmio_hit && (mmio_sel == REG_CONSOLE);

    // Expiry only happens on a genuine 1 -> 0 decrement, never under a load
    assign expire_set = !timer_we && (timer == 32'd1);
    assign timer_irq  = expired;

    mips_console_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_console_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (console_we),
        .data_in  (writedata[7:0]),
        .ready    (cons_ready),
        .data_out (cons_data),
        .valid    (cons_valid),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .drop     (fifo_drop)
    );

    // Assemble the STATUS word from live flags and FIFO occupancy
    always_comb begin
        status                  = '0;
        status[EXPIRED]         = expired;
        status[FULL]            = fifo_full;
        status[EMPTY]           = fifo_empty;
        status[OVERFLOW]        = overflow;
        status[COUNT_LSB +: 4]  = fifo_count;
    end

    // Zero-latency read mux: RAM, MMIO page, or 0 for unmapped addresses
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        readdata = '0;
        if (ram_hit) begin
            readdata = ram[ram_idx];
        end else if (mmio_hit) begin
            case (mmio_sel)
                REG_CYCLES:  readdata = cycles;
                REG_TIMER:   readdata = timer;
                REG_STATUS:  readdata = status;
                default:     readdata = '0;
            endcase
        end
    end

    // Data RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_idx] <= writedata;
    end

    // Free-running cycle counter and loadable countdown timer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles <= '0;
            timer  <= '0;
        end else begin
            cycles <= cycles + 32'd1;
            if (timer_we)            timer <= writedata;
            else if (timer != 32'd0) timer <= timer - 32'd1;
        end
    end

    // Sticky flags: hardware set takes priority over a write-1-to-clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            expired  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (expire_set)                         expired <= 1'b1;
            else if (status_we && writedata[EXPIRED]) expired <= 1'b0;

            if (fifo_drop)                            overflow <= 1'b1;
            else if (status_we && writedata[OVERFLOW]) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed bench for mips_dmem_responder: RAM, timer, console FIFO, overflow,
// async reset and cycle-counter wrap, each against hand-computed values.
module tb_mips_dmem_responder;

    localparam logic [31:0] CYC  = 32'hFFFF_FF00;
    localparam logic [31:0] TMR  = 32'hFFFF_FF04;
    localparam logic [31:0] STS  = 32'hFFFF_FF08;
    localparam logic [31:0] CONS = 32'hFFFF_FF0C;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  cons_data;
    logic        cons_valid;
    logic        cons_ready;
    logic        timer_irq;

    int checks   = 0;
    int failures = 0;

    mips_dmem_responder #(
        .DEPTH      (64),
        .FIFO_DEPTH (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .memwrite   (memwrite),
        .dataadr    (dataadr),
        .writedata  (writedata),
        .readdata   (readdata),
        .cons_data  (cons_data),
        .cons_valid (cons_valid),
        .cons_ready (cons_ready),
        .timer_irq  (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        step();
        memwrite  = 1'b0;
        writedata = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        dataadr = a;
        #1;
        v = readdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        logic [31:0] c0;
        logic [7:0]  drain_exp [8];

        reset      = 1'b0;
        memwrite   = 1'b0;
        dataadr    = '0;
        writedata  = '0;
        cons_ready = 1'b0;

        // Reset state
        step();
        step();
        rd(CYC, v);                    check("rst_cycles", v, 32'h0);
        rd(STS, v);                    check("rst_status", v, 32'h4);
        check("rst_cons_valid", {31'b0, cons_valid}, 32'h0);
        check("rst_cons_data",  {24'b0, cons_data},  32'h0);
        check("rst_irq",        {31'b0, timer_irq},  32'h0);
        reset = 1'b1;

        // CYCLES advances by one per edge
        rd(CYC, c0);
        repeat (5) step();
        rd(CYC, v);                    check("cycles_delta", v - c0, 32'd5);

        // RAM round trip, ignored low bits, out-of-range behaviour
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h0000_0010, v);          check("ram_rd", v, 32'hDEAD_BEEF);
        rd(32'h0000_0013, v);          check("ram_rd_lowbits", v, 32'hDEAD_BEEF);
        rd(32'h0000_1000, v);          check("ram_out_of_range", v, 32'h0);
        wr(32'h0000_0000, 32'h1111_1111);
        wr(32'h0000_1000, 32'h0000_CAFE);
        rd(32'h0000_0000, v);          check("ram_no_alias", v, 32'h1111_1111);
        rd(32'hFFFF_FF10, v);          check("unmapped_rd", v, 32'h0);
        rd(CONS, v);                   check("console_rd", v, 32'h0);

        // Read in the write cycle returns the old word
        memwrite  = 1'b1;
        dataadr   = 32'h0000_0010;
        writedata = 32'h1234_5678;
        #1;
        check("ram_rdw_old", readdata, 32'hDEAD_BEEF);
        step();
        memwrite  = 1'b0;
        check("ram_rdw_new", readdata, 32'h1234_5678);

        // Timer countdown and expiry
        wr(TMR, 32'd3);
        rd(TMR, v);                    check("tmr_load", v, 32'd3);
        step(); rd(TMR, v);            check("tmr_2", v, 32'd2);
        step(); rd(TMR, v);            check("tmr_1", v, 32'd1);
        check("tmr_irq_early", {31'b0, timer_irq}, 32'h0);
        step(); rd(TMR, v);            check("tmr_0", v, 32'd0);
        check("tmr_irq", {31'b0, timer_irq}, 32'h1);
        rd(STS, v);                    check("tmr_status", v, 32'h5);
        step(); rd(TMR, v);            check("tmr_stays_0", v, 32'd0);
        wr(STS, 32'h1);
        check("tmr_irq_clr", {31'b0, timer_irq}, 32'h0);

        // Reload while at 1 beats the expiry
        wr(TMR, 32'd2);
        step(); rd(TMR, v);            check("reload_at1_pre", v, 32'd1);
        wr(TMR, 32'd5);
        rd(TMR, v);                    check("reload_val", v, 32'd5);
        check("reload_no_irq", {31'b0, timer_irq}, 32'h0);

        // Expiry set beats a same-cycle clear
        repeat (4) step();
        rd(TMR, v);                    check("setclr_pre", v, 32'd1);
        wr(STS, 32'h1);
        check("set_beats_clr", {31'b0, timer_irq}, 32'h1);
        wr(STS, 32'h1);
        check("irq_clr2", {31'b0, timer_irq}, 32'h0);

        // Loading 0 stops the timer without expiry
        wr(TMR, 32'd3);
        wr(TMR, 32'd0);
        step();
        rd(TMR, v);                    check("load0_tmr", v, 32'd0);
        check("load0_no_irq", {31'b0, timer_irq}, 32'h0);

        // Console ordering under backpressure
        cons_ready = 1'b0;
        wr(CONS, 32'h41);
        check("cons_valid_after_push", {31'b0, cons_valid}, 32'h1);
        wr(CONS, 32'h42);
        wr(CONS, 32'h143);
        rd(STS, v);                    check("cons_status3", v, 32'h30);
        check("cons_hold", {24'b0, cons_data}, 32'h41);
        step();
        check("cons_hold2", {24'b0, cons_data}, 32'h41);
        cons_ready = 1'b1;
        check("cons_b0", {24'b0, cons_data}, 32'h41);
        step();
        check("cons_b1", {24'b0, cons_data}, 32'h42);
        step();
        check("cons_b2", {24'b0, cons_data}, 32'h43);
        check("cons_b2_valid", {31'b0, cons_valid}, 32'h1);
        step();
        check("cons_drained", {31'b0, cons_valid}, 32'h0);
        check("cons_drained_data", {24'b0, cons_data}, 32'h0);
        cons_ready = 1'b0;

        // Overflow: nine pushes into an eight-deep FIFO
        for (int i = 0; i < 9; i++) wr(CONS, 32'h50 + 32'(i));
        rd(STS, v);                    check("ovf_status", v, 32'h8A);
        wr(STS, 32'h8);
        rd(STS, v);                    check("ovf_clr", v, 32'h82);

        // Push into full FIFO with simultaneous pop is accepted
        cons_ready = 1'b1;
        wr(CONS, 32'h59);
        cons_ready = 1'b0;
        rd(STS, v);                    check("full_pushpop_status", v, 32'h82);
        drain_exp = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h59};
        cons_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_drain%0d", i), {24'b0, cons_data}, {24'b0, drain_exp[i]});
            step();
        end
        check("ovf_drained", {31'b0, cons_valid}, 32'h0);
        cons_ready = 1'b0;

        // Async reset mid-operation
        for (int i = 0; i < 4; i++) wr(CONS, 32'h60 + 32'(i));
        wr(TMR, 32'd100);
        step();
        #3;
        reset = 1'b0;
        #1;
        check("arst_valid", {31'b0, cons_valid}, 32'h0);
        check("arst_data",  {24'b0, cons_data},  32'h0);
        check("arst_irq",   {31'b0, timer_irq},  32'h0);
        rd(TMR, v);                    check("arst_timer", v, 32'h0);
        rd(CYC, v);                    check("arst_cycles", v, 32'h0);
        step();
        reset = 1'b1;
        rd(CYC, v);                    check("post_rst_cycles0", v, 32'h0);
        step();
        rd(CYC, v);                    check("post_rst_cycles1", v, 32'h1);
        check("post_rst_valid", {31'b0, cons_valid}, 32'h0);
        rd(STS, v);                    check("post_rst_status", v, 32'h4);

        // CYCLES wraps to zero
        dut.cycles = 32'hFFFF_FFFE;
        rd(CYC, v);                    check("wrap_pre", v, 32'hFFFF_FFFE);
        step();
        rd(CYC, v);                    check("wrap_max", v, 32'hFFFF_FFFF);
        step();
        rd(CYC, v);                    check("wrap_zero", v, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
